// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// One transfer in flight at a time; illegal addresses are answered locally without touching the bus.
module apb_req_arbiter #(
  parameter int               ADDRW   = 32,
  parameter int               DATAW   = 32,
  parameter int               NREQ    = 2,
  parameter logic [ADDRW-1:0] MAXADDR = 32'h24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_write,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  input  logic [NREQ*DATAW-1:0] req_wdata,
  output logic [NREQ-1:0]       rsp_valid,
  output logic                  rsp_err,
  output logic [DATAW-1:0]      rsp_rdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDRW-1:0]      paddr,
  output logic [DATAW-1:0]      pwdata,
  input  logic [DATAW-1:0]      prdata,
  output logic [2:0]            state_o
);

  // Handshake: a command transfers on a rising edge where req_valid[i] && req_ready[i];
  // requesters hold their command stable until then and may drop or replace it afterwards.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             gnt_q, gnt_d;
  logic             wr_q, wr_d;
  logic             err_q, err_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [DATAW-1:0] wdata_q, wdata_d;
  logic [DATAW-1:0] rdata_q, rdata_d;

  logic             win;
  logic [ADDRW-1:0] sel_addr;
  logic             legal;

  assign state_o = state_q;

  always_comb begin
    win = ptr_q;
    if (!(req_valid[0] && req_valid[1])) win = req_valid[1];
    sel_addr = win ? req_addr[ADDRW +: ADDRW] : req_addr[0 +: ADDRW];
    legal    = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAXADDR);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    req_ready = '0;

    case (state_q)
      S_IDLE: begin
        if ((|req_valid) && !rst) begin
          req_ready[win] = 1'b1;
          gnt_d   = win;
          wr_d    = req_write[win];
          addr_d  = sel_addr;
          wdata_d = win ? req_wdata[DATAW +: DATAW] : req_wdata[0 +: DATAW];
          err_d   = !legal;
          rdata_d = '0;
          ptr_d   = !win;
          state_d = legal ? S_SETUP : S_RESP;
        end
      end
      S_SETUP:   state_d = S_ACCESS;
      S_ACCESS:  state_d = wr_q ? S_RESP : S_CAPTURE;
      S_CAPTURE: begin
        rdata_d = prdata;
        state_d = S_RESP;
      end
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Bus and response outputs decode from registered state only, so prdata never reaches them combinationally.
  always_comb begin
    psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    penable   = (state_q == S_ACCESS);
    pwrite    = psel ? wr_q : 1'b0;
    paddr     = psel ? addr_q : '0;
    pwdata    = psel ? wdata_q : '0;
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[gnt_q] = 1'b1;
    rsp_err   = (state_q == S_RESP) && err_q;
    rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a small behavioural model of the APB register slave.
module tb_apb_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slv_rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req_write = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  apb_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .state_o(state_o)
  );

  // Slave model: registers prdata at the edge ending ACCESS and clears it one cycle later.
  logic [31:0] mem [0:9];
  always @(posedge clk) begin
    if (slv_rst) begin
      for (int k = 0; k < 10; k++) mem[k] <= 32'h0;
      mem[5] <= 32'h0A9B0024;
      prdata <= 32'h0;
    end else begin
      prdata <= 32'h0;
      if (psel && penable && (paddr <= 32'h24)) begin
        if (pwrite) mem[paddr[5:2]] <= pwdata;
        else        prdata <= mem[paddr[5:2]];
      end
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bit          hs [2];
  bit          arm [2];
  logic        arm_w [2];
  logic [31:0] arm_a [2];
  logic [31:0] arm_d [2];
  logic        cur_w = 1'b0;
  logic [31:0] cur_a = '0;
  logic [31:0] cur_d = '0;

  int          g_id_q [$];
  int          g_cyc_q [$];
  int          r_cyc_q [$];
  logic [1:0]  r_v_q [$];
  logic        r_err_q [$];
  logic [31:0] r_rd_q [$];
  int psel_cnt, pen_cnt, psel_first, pen_first;

  task automatic clear_logs();
    g_id_q.delete(); g_cyc_q.delete(); r_cyc_q.delete();
    r_v_q.delete(); r_err_q.delete(); r_rd_q.delete();
    psel_cnt = 0; pen_cnt = 0; psel_first = -1; pen_first = -1;
  endtask

  task automatic arm_cmd(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    arm[i] = 1'b1; arm_w[i] = w; arm_a[i] = a; arm_d[i] = d;
  endtask

  // One clock: update requester inputs at the falling edge, then sample outputs 1ns later.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (hs[i]) begin req_valid[i] = 1'b0; hs[i] = 1'b0; end
      if (arm[i]) begin
        req_valid[i] = 1'b1;
        req_write[i] = arm_w[i];
        req_addr[i*32 +: 32] = arm_a[i];
        req_wdata[i*32 +: 32] = arm_d[i];
        arm[i] = 1'b0;
      end
    end
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        hs[i] = 1'b1;
        g_id_q.push_back(i);
        g_cyc_q.push_back(cyc);
        cur_a = req_addr[i*32 +: 32];
        cur_w = req_write[i];
        cur_d = req_wdata[i*32 +: 32];
      end
    end
    total++;
    if (psel) begin
      psel_cnt++;
      if (psel_first < 0) psel_first = cyc;
      if (paddr !== cur_a || pwrite !== cur_w || (cur_w && pwdata !== cur_d)) begin
        bad++;
        $display("FAIL bus_fields cyc=%0d got paddr=%h pwrite=%b pwdata=%h want paddr=%h pwrite=%b pwdata=%h",
                 cyc, paddr, pwrite, pwdata, cur_a, cur_w, cur_d);
      end
    end else if (penable !== 1'b0 || paddr !== 32'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin
      bad++;
      $display("FAIL bus_idle cyc=%0d got penable=%b paddr=%h pwdata=%h pwrite=%b want all 0",
               cyc, penable, paddr, pwdata, pwrite);
    end
    if (penable) begin
      pen_cnt++;
      if (pen_first < 0) pen_first = cyc;
    end
    if (rsp_valid !== 2'b00) begin
      r_cyc_q.push_back(cyc);
      r_v_q.push_back(rsp_valid);
      r_err_q.push_back(rsp_err);
      r_rd_q.push_back(rsp_rdata);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic int lat_of(input int k);
    if (k < r_cyc_q.size() && k < g_cyc_q.size()) return r_cyc_q[k] - g_cyc_q[k];
    return -1;
  endfunction
  function automatic int gid_of(input int k);
    return (k < g_id_q.size()) ? g_id_q[k] : -1;
  endfunction
  function automatic logic [1:0] rv_of(input int k);
    return (k < r_v_q.size()) ? r_v_q[k] : 2'bxx;
  endfunction
  function automatic logic err_of(input int k);
    return (k < r_err_q.size()) ? r_err_q[k] : 1'bx;
  endfunction
  function automatic logic [31:0] rd_of(input int k);
    return (k < r_rd_q.size()) ? r_rd_q[k] : 32'hxxxxxxxx;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    run(2);
    total++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00 || state_o !== 3'd0) begin
      bad++;
      $display("FAIL reset_state got psel=%b penable=%b rsp_valid=%b req_ready=%b state=%0d want 0",
               psel, penable, rsp_valid, req_ready, state_o);
    end
    rst = 1'b0;
    slv_rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
        bad++;
        $display("FAIL idle_quiet cyc=%0d got psel=%b penable=%b rsp_valid=%b req_ready=%b want 0",
                 cyc, psel, penable, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_write_read();
    clear_logs();
    arm_cmd(0, 1'b1, 32'h10, 32'hDEADBEEF);
    run(7);
    total++;
    if (lat_of(0) !== 3 || rv_of(0) !== 2'b01 || err_of(0) !== 1'b0 || rd_of(0) !== 32'h0) begin
      bad++;
      $display("FAIL write_rsp got lat=%0d rv=%b err=%b rd=%h want lat=3 rv=01 err=0 rd=0",
               lat_of(0), rv_of(0), err_of(0), rd_of(0));
    end
    total++;
    if (psel_cnt !== 2 || pen_cnt !== 1 || pen_first !== psel_first + 1) begin
      bad++;
      $display("FAIL write_bus got psel_cycles=%0d pen_cycles=%0d pen_offset=%0d want 2 1 1",
               psel_cnt, pen_cnt, pen_first - psel_first);
    end
    clear_logs();
    arm_cmd(0, 1'b0, 32'h10, 32'h0);
    run(8);
    total++;
    if (lat_of(0) !== 4 || rv_of(0) !== 2'b01 || err_of(0) !== 1'b0 || rd_of(0) !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL read_rsp got lat=%0d rv=%b err=%b rd=%h want lat=4 rv=01 err=0 rd=deadbeef",
               lat_of(0), rv_of(0), err_of(0), rd_of(0));
    end
    total++;
    if (psel_cnt !== 2 || pen_cnt !== 1 || pen_first !== psel_first + 1) begin
      bad++;
      $display("FAIL read_bus got psel_cycles=%0d pen_cycles=%0d pen_offset=%0d want 2 1 1",
               psel_cnt, pen_cnt, pen_first - psel_first);
    end
  endtask

  task automatic test_reset_value_read();
    clear_logs();
    arm_cmd(1, 1'b0, 32'h14, 32'h0);
    run(8);
    total++;
    if (lat_of(0) !== 4 || rv_of(0) !== 2'b10 || err_of(0) !== 1'b0 || rd_of(0) !== 32'h0A9B0024) begin
      bad++;
      $display("FAIL resetval_read got lat=%0d rv=%b err=%b rd=%h want lat=4 rv=10 err=0 rd=0a9b0024",
               lat_of(0), rv_of(0), err_of(0), rd_of(0));
    end
  endtask

  task automatic test_contention();
    clear_logs();
    arm_cmd(0, 1'b1, 32'h0C, 32'h12345678);
    arm_cmd(1, 1'b0, 32'h0C, 32'h0);
    run(12);
    total++;
    if (gid_of(0) !== 0 || gid_of(1) !== 1 || rv_of(0) !== 2'b01 || rv_of(1) !== 2'b10) begin
      bad++;
      $display("FAIL contend_order got grants=%0d,%0d rsps=%b,%b want 0,1 01,10",
               gid_of(0), gid_of(1), rv_of(0), rv_of(1));
    end
    total++;
    if (rd_of(1) !== 32'h12345678 || lat_of(1) !== 4 || rd_of(0) !== 32'h0) begin
      bad++;
      $display("FAIL contend_data got rd1=%h lat1=%0d rd0=%h want 12345678 4 0", rd_of(1), lat_of(1), rd_of(0));
    end
    total++;
    if (g_cyc_q.size() < 2 || g_cyc_q[1] - g_cyc_q[0] !== 4) begin
      bad++;
      $display("FAIL contend_spacing got grants=%0d gap=%0d want 2 grants gap=4",
               g_cyc_q.size(), (g_cyc_q.size() < 2) ? -1 : g_cyc_q[1] - g_cyc_q[0]);
    end
    clear_logs();
    arm_cmd(0, 1'b0, 32'h0C, 32'h0);
    arm_cmd(1, 1'b1, 32'h20, 32'h00000001);
    run(12);
    total++;
    if (gid_of(0) !== 0 || gid_of(1) !== 1 || rd_of(0) !== 32'h12345678 || err_of(1) !== 1'b0) begin
      bad++;
      $display("FAIL contend_again got grants=%0d,%0d rd0=%h err1=%b want 0,1 12345678 0",
               gid_of(0), gid_of(1), rd_of(0), err_of(1));
    end
  endtask

  task automatic test_illegal_addr();
    clear_logs();
    arm_cmd(0, 1'b0, 32'h28, 32'h0);
    run(3);
    arm_cmd(0, 1'b0, 32'h05, 32'h0);
    run(3);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (lat_of(k) !== 1 || rv_of(k) !== 2'b01 || err_of(k) !== 1'b1 || rd_of(k) !== 32'h0) begin
        bad++;
        $display("FAIL illegal_rsp%0d got lat=%0d rv=%b err=%b rd=%h want lat=1 rv=01 err=1 rd=0",
                 k, lat_of(k), rv_of(k), err_of(k), rd_of(k));
      end
    end
    total++;
    if (psel_cnt !== 0) begin
      bad++;
      $display("FAIL illegal_nobus got psel_cycles=%0d want 0", psel_cnt);
    end
  endtask

  task automatic test_reset_mid_transfer();
    bit seen;
    clear_logs();
    arm_cmd(0, 1'b0, 32'h10, 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      seen = (penable === 1'b1);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL midrst_access got no ACCESS within 10 cycles want ACCESS");
    end
    rst = 1'b1;
    step();
    total++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 2'b00 || state_o !== 3'd0) begin
      bad++;
      $display("FAIL midrst_idle got psel=%b penable=%b rsp_valid=%b state=%0d want 0 0 00 0",
               psel, penable, rsp_valid, state_o);
    end
    rst = 1'b0;
    run(6);
    total++;
    if (r_cyc_q.size() !== 0) begin
      bad++;
      $display("FAIL midrst_norsp got responses=%0d want 0", r_cyc_q.size());
    end
    clear_logs();
    arm_cmd(0, 1'b0, 32'h10, 32'h0);
    arm_cmd(1, 1'b0, 32'h14, 32'h0);
    run(12);
    total++;
    if (gid_of(0) !== 0 || gid_of(1) !== 1 || lat_of(0) !== 4 || rd_of(0) !== 32'hDEADBEEF ||
        rd_of(1) !== 32'h0A9B0024) begin
      bad++;
      $display("FAIL midrst_recover got grants=%0d,%0d lat0=%0d rd0=%h rd1=%h want 0,1 4 deadbeef 0a9b0024",
               gid_of(0), gid_of(1), lat_of(0), rd_of(0), rd_of(1));
    end
  endtask

  initial begin
    hs[0] = 1'b0; hs[1] = 1'b0;
    arm[0] = 1'b0; arm[1] = 1'b0;
    clear_logs();
    test_reset();
    test_write_read();
    test_reset_value_read();
    test_contention();
    test_illegal_addr();
    test_reset_mid_transfer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-requester round-robin arbiter and APB master that shares the `apb_slave` register block (ten 32-bit registers at 0x00–0x24) between requesters such as a boot-time config sequencer and a host port. Each requester issues single read or write commands through a valid/ready handshake. The block runs one APB transfer at a time: a SETUP cycle, then an ACCESS cycle, then read-data capture. It returns a one-cycle response strobe to the originating requester. Commands to out-of-range or unaligned addresses are rejected locally and never reach the bus.

## Interface
Parameters:
- `ADDRW`, 32, address width
- `DATAW`, 32, data width
- `NREQ`, 2, number of requesters (fixed at 2 for this revision)
- `MAXADDR`, 32'h24, highest legal word address

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  NREQ  command valid, per requester
- `req_ready`  out  NREQ  command accepted (one-hot, IDLE only)
- `req_write`  in  NREQ  1=write, 0=read
- `req_addr`  in  NREQ*ADDRW  flattened; requester i at [i*ADDRW +: ADDRW]
- `req_wdata`  in  NREQ*DATAW  flattened write data
- `rsp_valid`  out  NREQ  one-cycle, one-hot completion strobe
- `rsp_err`  out  1  qualifies `rsp_valid`; 1=rejected address
- `rsp_rdata`  out  DATAW  read data; valid with `rsp_valid` on reads
- `psel`, `penable`, `pwrite`  out  1  APB controls
- `paddr`  out  ADDRW  APB address
- `pwdata`  out  DATAW  APB write data
- `prdata`  in  DATAW  APB read data (registered by slave)

## Operation
- Reset: all outputs 0, state IDLE, RR pointer = 0 (requester 0 has priority first).
- States:
  - IDLE: if any `req_valid`, grant one requester.
  - SETUP: `psel`=1, `penable`=0.
  - ACCESS: `psel`=1, `penable`=1.
  - CAPTURE (reads only): `psel`=0; `rsp_rdata` <= `prdata`.
  - RESP: assert `rsp_valid[g]`; go to IDLE.
- Grant:
  - `req_ready[g]` is combinational: IDLE && `req_valid[g]` && g wins RR.
  - On the handshake, latch addr/wdata/write/g.
  - Pointer moves to the other requester after every grant, including rejected ones.
- Legality: addr[1:0]==0 and addr<=MAXADDR.
  - Illegal: IDLE→RESP, no bus activity, `rsp_err`=1, `rsp_rdata`=0.
- Paths:
  - Legal write: IDLE→SETUP→ACCESS→RESP.
  - Legal read: IDLE→SETUP→ACCESS→CAPTURE→RESP.
- `paddr`/`pwdata`/`pwrite` hold the latched values from SETUP through ACCESS; they are 0 otherwise.
- `rsp_err`=0 on legal completions; `rsp_rdata`=0 on writes.
- No new grant until RESP completes. Requesters hold commands while `req_ready`=0.

## Timing
- Grant at edge E0. SETUP is the cycle after E0, ACCESS the next cycle.
- Slave registers `prdata` at the edge ending ACCESS; `prdata` is valid only during CAPTURE (the slave clears it the next cycle).
- Write latency: `rsp_valid` in the 3rd cycle after E0.
- Read latency: `rsp_valid` in the 4th cycle after E0.
- Illegal address: `rsp_valid` in the 1st cycle after E0.
- Minimum spacing between legal transfers: one IDLE cycle after RESP, so the slave is back in its SETUP state before the next `psel`.
- Simultaneous `req_valid` from both requesters: the pointer holder wins; the other is granted at the next IDLE.
- `rst` high in any state: next edge forces IDLE, all outputs 0, pointer 0. An in-flight command is dropped with no response.
- No combinational path from `prdata` to any output.

## Test plan
- Reset then idle: `rst` 2 cycles → `psel`, `penable`, `rsp_valid`, `req_ready` all 0 for 10 cycles with no requests.
- Write/read: req0 writes 0xDEADBEEF to 0x10, then reads 0x10.
  - `psel` 2 cycles with `penable` in the 2nd.
  - Write response at E0+3; read response at E0+4 with `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Reset-value read: req1 reads 0x14 → `rsp_valid`=2'b10, `rsp_rdata`=0x0A9B0024.
- Contention: both requesters hold valid (req0 writes 0x0C=0x12345678, req1 reads 0x0C).
  - Order is req0 then req1.
  - req1 receives 0x12345678.
  - The next simultaneous pair is granted req0 first again, since the pointer was restored.
- Illegal address: req0 reads 0x28, then 0x05 → each gives `rsp_err`=1 and `rsp_rdata`=0 at E0+1, with `psel` never asserted.
- Reset mid-transfer: `rst` during ACCESS → next cycle IDLE, `psel`=0, no `rsp_valid`; a subsequent read of the target succeeds normally.
